// File: rtl/crosswalk_phase_ctrl_if.sv
// Frame-event inputs and light-phase outputs of the crosswalk phase sequencer.
// The master side drives frame events, the slave side is the sequencer.
interface crosswalk_phase_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             v_finish;
  logic             coord_valid;
  logic             ped_present;
  logic             force_red;
  logic             tr_light;
  logic             tr_light_tick;
  logic             yellow;
  logic [2:0]       phase;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       ext_cnt;

  modport master (
    output v_finish, coord_valid, ped_present, force_red,
    input  tr_light, tr_light_tick, yellow, phase, frame_cnt, ext_cnt
  );

  modport slave (
    input  v_finish, coord_valid, ped_present, force_red,
    output tr_light, tr_light_tick, yellow, phase, frame_cnt, ext_cnt
  );
endinterface

// File: rtl/crosswalk_phase_ctrl.sv
// Frame-driven traffic-light phase sequencer feeding the crosswalk detection path.
// Every output is registered, and phase is the state register itself.
//
// state    | meaning
// CALIB    | waiting for the first crosswalk box fix (coord_valid)
// GREEN    | cars go; force_red may cut it short after MIN_GREEN frames
// YELLOW   | cars clearing
// ALLRED_A | clearance before pedestrian phase
// RED      | pedestrians go; may be extended while ped_present
// ALLRED_B | clearance before car phase
module crosswalk_phase_ctrl #(
  parameter int GREEN_FRAMES  = 300,
  parameter int YELLOW_FRAMES = 60,
  parameter int ALLRED_FRAMES = 30,
  parameter int RED_FRAMES    = 240,
  parameter int EXT_FRAMES    = 60,
  parameter int MAX_EXT       = 2,
  parameter int MIN_GREEN     = 90,
  parameter int CNT_W         = 10
) (
  input  logic                  pclk,
  input  logic                  reset,
  crosswalk_phase_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CALIB    = 3'd0,
    GREEN    = 3'd1,
    YELLOW   = 3'd2,
    ALLRED_A = 3'd3,
    RED      = 3'd4,
    ALLRED_B = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_FRAMES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_FRAMES - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_FRAMES - 1);
  localparam logic [CNT_W-1:0] EXT_LAST    = CNT_W'(EXT_FRAMES - 1);
  localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [1:0]       MAX_EXT_V   = 2'(MAX_EXT);

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       ext_cnt;
  logic             force_pend;
  logic             tr_light;
  logic             tr_light_tick;
  logic             yellow;

  // A force_red arriving on the same cycle as v_finish counts immediately.
  logic             force_now;
  logic [CNT_W-1:0] red_last;

  assign force_now = force_pend | bus.force_red;
  assign red_last  = (ext_cnt == 2'd0) ? RED_LAST : EXT_LAST;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state         <= CALIB;
      frame_cnt     <= '0;
      ext_cnt       <= 2'd0;
      force_pend    <= 1'b0;
      tr_light      <= 1'b0;
      tr_light_tick <= 1'b0;
      yellow        <= 1'b0;
    end else begin
      tr_light_tick <= 1'b0;
      case (state)
        CALIB: begin
          if (bus.coord_valid) begin
            state         <= GREEN;
            frame_cnt     <= '0;
            tr_light      <= 1'b1;
            tr_light_tick <= 1'b1;
          end
        end
        GREEN: begin
          if (bus.force_red) force_pend <= 1'b1;
          if (bus.v_finish) begin
            if (frame_cnt == GREEN_LAST || (force_now && frame_cnt >= MIN_G_LAST)) begin
              state     <= YELLOW;
              frame_cnt <= '0;
              yellow    <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        YELLOW: begin
          if (bus.v_finish) begin
            if (frame_cnt == YELLOW_LAST) begin
              state     <= ALLRED_A;
              frame_cnt <= '0;
              yellow    <= 1'b0;
              tr_light  <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ALLRED_A: begin
          if (bus.v_finish) begin
            if (frame_cnt == ALLRED_LAST) begin
              state         <= RED;
              frame_cnt     <= '0;
              ext_cnt       <= 2'd0;
              force_pend    <= 1'b0;
              tr_light_tick <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        RED: begin
          if (bus.v_finish) begin
            if (frame_cnt == red_last) begin
              frame_cnt <= '0;
              if (bus.ped_present && ext_cnt < MAX_EXT_V) begin
                ext_cnt <= ext_cnt + 2'd1;
              end else begin
                state   <= ALLRED_B;
                ext_cnt <= 2'd0;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ALLRED_B: begin
          if (bus.v_finish) begin
            if (frame_cnt == ALLRED_LAST) begin
              state         <= GREEN;
              frame_cnt     <= '0;
              tr_light      <= 1'b1;
              tr_light_tick <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= CALIB;
          frame_cnt <= '0;
          ext_cnt   <= 2'd0;
          tr_light  <= 1'b0;
          yellow    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase         = state;
  assign bus.frame_cnt     = frame_cnt;
  assign bus.ext_cnt       = ext_cnt;
  assign bus.tr_light      = tr_light;
  assign bus.tr_light_tick = tr_light_tick;
  assign bus.yellow        = yellow;

endmodule

// File: tb/tb_crosswalk_phase_ctrl.sv
// Directed bench for crosswalk_phase_ctrl using the reduced test-plan timing
// (GREEN=4, YELLOW=2, ALLRED=1, RED=3, EXT=2, MAX_EXT=1, MIN_GREEN=2).
module tb_crosswalk_phase_ctrl;
  logic pclk;
  logic reset;
  int   checks;
  int   errors;

  crosswalk_phase_ctrl_if #(.CNT_W(10)) bus ();

  crosswalk_phase_ctrl #(
    .GREEN_FRAMES (4),
    .YELLOW_FRAMES(2),
    .ALLRED_FRAMES(1),
    .RED_FRAMES   (3),
    .EXT_FRAMES   (2),
    .MAX_EXT      (1),
    .MIN_GREEN    (2),
    .CNT_W        (10)
  ) dut (
    .pclk (pclk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pclk cycle with the given inputs; returns at the next negedge.
  task automatic step(input logic vf, input logic cv, input logic fr);
    bus.v_finish    = vf;
    bus.coord_valid = cv;
    bus.force_red   = fr;
    @(negedge pclk);
    bus.v_finish    = 1'b0;
    bus.coord_valid = 1'b0;
    bus.force_red   = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ph, input logic tl,
                           input logic tk, input logic [9:0] fc);
    chk({tag, ".phase"}, 32'(bus.phase), 32'(ph));
    chk({tag, ".tr_light"}, 32'(bus.tr_light), 32'(tl));
    chk({tag, ".tick"}, 32'(bus.tr_light_tick), 32'(tk));
    chk({tag, ".frame_cnt"}, 32'(bus.frame_cnt), 32'(fc));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.v_finish    = 1'b0;
    bus.coord_valid = 1'b0;
    bus.ped_present = 1'b0;
    bus.force_red   = 1'b0;
    repeat (2) @(negedge pclk);
    chk_state("reset", 3'd0, 1'b0, 1'b0, 10'd0);
    chk("reset.yellow", 32'(bus.yellow), 32'd0);
    chk("reset.ext", 32'(bus.ext_cnt), 32'd0);
    reset = 1'b0;
    @(negedge pclk);

    // Calibration: frames ignored without coord_valid
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("calib.tick", 32'(bus.tr_light_tick), 32'd0);
    end
    chk_state("calib", 3'd0, 1'b0, 1'b0, 10'd0);

    // coord_valid together with v_finish: enter GREEN without counting
    step(1'b1, 1'b1, 1'b0);
    chk_state("calib_exit", 3'd1, 1'b1, 1'b1, 10'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("green.tick_one_cycle", 32'(bus.tr_light_tick), 32'd0);

    // Full cycle, no pedestrian
    frames(3);
    chk_state("green3", 3'd1, 1'b1, 1'b0, 10'd3);
    frames(1);
    chk_state("yellow", 3'd2, 1'b1, 1'b0, 10'd0);
    chk("yellow.out", 32'(bus.yellow), 32'd1);
    frames(2);
    chk_state("allred_a", 3'd3, 1'b0, 1'b0, 10'd0);
    chk("allred_a.yellow", 32'(bus.yellow), 32'd0);
    frames(1);
    chk_state("red", 3'd4, 1'b0, 1'b1, 10'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("red.tick_off", 32'(bus.tr_light_tick), 32'd0);
    frames(2);
    chk_state("red2", 3'd4, 1'b0, 1'b0, 10'd2);
    frames(1);
    chk_state("allred_b", 3'd5, 1'b0, 1'b0, 10'd0);
    frames(1);
    chk_state("green_again", 3'd1, 1'b1, 1'b1, 10'd0);

    // Extension: pedestrian present throughout RED
    frames(7);
    chk_state("ext.red", 3'd4, 1'b0, 1'b1, 10'd0);
    bus.ped_present = 1'b1;
    frames(3);
    chk_state("ext.extended", 3'd4, 1'b0, 1'b0, 10'd0);
    chk("ext.cnt1", 32'(bus.ext_cnt), 32'd1);
    frames(1);
    chk_state("ext.frame1", 3'd4, 1'b0, 1'b0, 10'd1);
    frames(1);
    chk_state("ext.max_exit", 3'd5, 1'b0, 1'b0, 10'd0);
    chk("ext.cleared", 32'(bus.ext_cnt), 32'd0);
    bus.ped_present = 1'b0;
    frames(1);
    chk_state("ext.green", 3'd1, 1'b1, 1'b1, 10'd0);

    // Force red at GREEN frame 0: YELLOW on the 2nd v_finish
    step(1'b0, 1'b0, 1'b1);
    frames(1);
    chk_state("force.g1", 3'd1, 1'b1, 1'b0, 10'd1);
    frames(1);
    chk_state("force.yellow", 3'd2, 1'b1, 1'b0, 10'd0);
    frames(3);
    chk_state("force.red", 3'd4, 1'b0, 1'b1, 10'd0);
    step(1'b0, 1'b0, 1'b1);
    frames(4);
    chk_state("force.green", 3'd1, 1'b1, 1'b1, 10'd0);
    frames(3);
    chk_state("force.ignored", 3'd1, 1'b1, 1'b0, 10'd3);
    frames(1);
    chk_state("force.normal_end", 3'd2, 1'b1, 1'b0, 10'd0);

    // Asynchronous reset in YELLOW at frame_cnt=1
    frames(1);
    chk_state("pre_reset", 3'd2, 1'b1, 1'b0, 10'd1);
    #2 reset = 1'b1;
    #1;
    chk_state("async_reset", 3'd0, 1'b0, 1'b0, 10'd0);
    chk("async_reset.yellow", 32'(bus.yellow), 32'd0);
    @(negedge pclk);
    reset = 1'b0;
    frames(3);
    chk_state("post_reset", 3'd0, 1'b0, 1'b0, 10'd0);

    // force_red and v_finish in the same cycle with MIN_GREEN met
    step(1'b0, 1'b1, 1'b0);
    chk_state("recal", 3'd1, 1'b1, 1'b1, 10'd0);
    frames(1);
    step(1'b1, 1'b0, 1'b1);
    chk_state("force_same_cycle", 3'd2, 1'b1, 1'b0, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
